// File: rtl/bus_fabric_n.sv
// -----------------------------------------------------------------------------
// bus_fabric_n
//
// Registered single-master bus fabric. Decodes the region-select field of the
// master address to one of N_SLAVES one-hot chip enables. It holds the request
// stable towards the slave while waiting, and returns the selected slave's read
// data to the master with a single-cycle grant pulse.
//
// Optional feature macro: BUS_FABRIC_TIMEOUT_ERR_EN
//   defined   : wait-state timeout counter present; misses and timeouts
//               complete with o_M_ERR=1.
//   undefined : no counter; WAIT lasts until the selected slave grants;
//               o_M_ERR is always 0. Unmapped accesses still complete with a
//               grant pulse and o_M_RDATA=0.
//
// Ports
//   i_CLK, i_RST        clock, asynchronous active-high reset
//   i_M_REQ/WE/RE/HB    master request, direction and size code
//   i_M_ADDR/WDATA      master address / write data
//   o_M_GNT             one-cycle completion pulse
//   o_M_RDATA/o_M_ERR   read data / error flag, valid with o_M_GNT
//   o_S_CE              one-hot slave chip enable
//   o_S_REQ/WE/RE/HB    slave request, direction, size code
//   o_S_ADDR/WDATA      latched address (select field and above zeroed) / data
//   i_S_GNT             per-slave grant
//   i_S_RDATA           packed slave read data, slave i at [i*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module bus_fabric_n #(
    parameter int N_SLAVES = 8,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int SEL_MSB  = 31,
    parameter int SEL_LSB  = 28,
    parameter int BASE_SEL = 8,
    parameter int TIMEOUT  = 15
) (
    input  logic                         i_CLK,
    input  logic                         i_RST,
    input  logic                         i_M_REQ,
    input  logic                         i_M_WE,
    input  logic                         i_M_RE,
    input  logic [1:0]                   i_M_HB,
    input  logic [ADDR_W-1:0]            i_M_ADDR,
    input  logic [DATA_W-1:0]            i_M_WDATA,
    output logic                         o_M_GNT,
    output logic [DATA_W-1:0]            o_M_RDATA,
    output logic                         o_M_ERR,
    output logic [N_SLAVES-1:0]          o_S_CE,
    output logic                         o_S_REQ,
    output logic                         o_S_WE,
    output logic                         o_S_RE,
    output logic [1:0]                   o_S_HB,
    output logic [ADDR_W-1:0]            o_S_ADDR,
    output logic [DATA_W-1:0]            o_S_WDATA,
    input  logic [N_SLAVES-1:0]          i_S_GNT,
    input  logic [N_SLAVES*DATA_W-1:0]   i_S_RDATA
);

    localparam int SEL_W   = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int BASE_HI = BASE_SEL + N_SLAVES;
    // Keeps only the offset bits below the region-select field.
    localparam logic [ADDR_W-1:0] ADDR_MASK = (ADDR_W'(1) << SEL_LSB) - ADDR_W'(1);

`ifdef BUS_FABRIC_TIMEOUT_ERR_EN
    localparam int   CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic MISS_ERR = 1'b1;
`else
    localparam logic MISS_ERR = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N_SLAVES-1:0] ce_q, ce_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic                re_q, re_d;
    logic [1:0]          hb_q, hb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                gnt_q, gnt_d;
    logic                err_q, err_d;
`ifdef BUS_FABRIC_TIMEOUT_ERR_EN
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    // Unpack the slave read-data bus so the selected slice is a plain index.
    logic [DATA_W-1:0] s_rdata [N_SLAVES];
    for (genvar g = 0; g < N_SLAVES; g++) begin : g_unpack
        assign s_rdata[g] = i_S_RDATA[g*DATA_W +: DATA_W];
    end

    // Region decode of the incoming master address.
    logic [31:0]      fld;
    logic             hit;
    logic [SEL_W-1:0] sel_dec;
    logic             s_gnt;

    always_comb begin
        fld     = 32'(i_M_ADDR[SEL_MSB:SEL_LSB]);
        hit     = (fld >= 32'(BASE_SEL)) && (fld < 32'(BASE_HI));
        sel_dec = SEL_W'(fld - 32'(BASE_SEL));
        // Only the addressed slave's grant counts; others are ignored.
        s_gnt   = i_S_GNT[sel_q];
    end

    always_comb begin
        state_d = state_q;
        ce_d    = ce_q;
        req_d   = req_q;
        we_d    = we_q;
        re_d    = re_q;
        hb_d    = hb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        gnt_d   = 1'b0;
        err_d   = 1'b0;
`ifdef BUS_FABRIC_TIMEOUT_ERR_EN
        cnt_d   = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // gnt_q is only ever set on entry to RESP, so IDLE never sees
                // a master that is still holding the request just granted.
                if (i_M_REQ && (i_M_WE || i_M_RE)) begin
                    if (hit) begin
                        ce_d    = N_SLAVES'(1) << sel_dec;
                        req_d   = 1'b1;
                        we_d    = i_M_WE;
                        re_d    = i_M_RE & ~i_M_WE;   // write wins when both set
                        hb_d    = i_M_HB;
                        addr_d  = i_M_ADDR & ADDR_MASK;
                        wdata_d = i_M_WDATA;
                        sel_d   = sel_dec;
                        state_d = ST_WAIT;
                    end else begin
                        // Unmapped: complete straight away, no chip enable.
                        rdata_d = '0;
                        gnt_d   = 1'b1;
                        err_d   = MISS_ERR;
                        state_d = ST_RESP;
                    end
                end
            end

            ST_WAIT: begin
                // Grant is tested first so it beats a same-cycle timeout.
                if (s_gnt) begin
                    rdata_d = we_q ? '0 : s_rdata[sel_q];
                    ce_d    = '0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    re_d    = 1'b0;
                    gnt_d   = 1'b1;
                    state_d = ST_RESP;
`ifdef BUS_FABRIC_TIMEOUT_ERR_EN
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // This cycle brings the count to TIMEOUT: abort.
                    rdata_d = '0;
                    ce_d    = '0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    re_d    = 1'b0;
                    gnt_d   = 1'b1;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
`ifdef BUS_FABRIC_TIMEOUT_ERR_EN
                cnt_d   = '0;
`endif
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= ST_IDLE;
            ce_q    <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            hb_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            gnt_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef BUS_FABRIC_TIMEOUT_ERR_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ce_q    <= ce_d;
            req_q   <= req_d;
            we_q    <= we_d;
            re_q    <= re_d;
            hb_q    <= hb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
`ifdef BUS_FABRIC_TIMEOUT_ERR_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign o_M_GNT   = gnt_q;
    assign o_M_RDATA = rdata_q;
    assign o_M_ERR   = err_q;
    assign o_S_CE    = ce_q;
    assign o_S_REQ   = req_q;
    assign o_S_WE    = we_q;
    assign o_S_RE    = re_q;
    assign o_S_HB    = hb_q;
    assign o_S_ADDR  = addr_q;
    assign o_S_WDATA = wdata_q;

endmodule

// File: tb/tb_bus_fabric_n.sv
// Directed bench for bus_fabric_n (default parameters). Latency is counted
// with the accept cycle (request seen in IDLE) as cycle 1.
module tb_bus_fabric_n;

    localparam int N  = 8;
    localparam int AW = 32;
    localparam int DW = 32;

`ifdef BUS_FABRIC_TIMEOUT_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            m_req, m_we, m_re;
    logic [1:0]      m_hb;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic            m_gnt;
    logic [DW-1:0]   m_rdata;
    logic            m_err;
    logic [N-1:0]    s_ce;
    logic            s_req, s_we, s_re;
    logic [1:0]      s_hb;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [N-1:0]    s_gnt;
    logic [N*DW-1:0] s_rdata;

    always #5 clk = ~clk;

    bus_fabric_n #(
        .N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW),
        .SEL_MSB(31), .SEL_LSB(28), .BASE_SEL(8), .TIMEOUT(15)
    ) dut (
        .i_CLK(clk), .i_RST(rst),
        .i_M_REQ(m_req), .i_M_WE(m_we), .i_M_RE(m_re), .i_M_HB(m_hb),
        .i_M_ADDR(m_addr), .i_M_WDATA(m_wdata),
        .o_M_GNT(m_gnt), .o_M_RDATA(m_rdata), .o_M_ERR(m_err),
        .o_S_CE(s_ce), .o_S_REQ(s_req), .o_S_WE(s_we), .o_S_RE(s_re),
        .o_S_HB(s_hb), .o_S_ADDR(s_addr), .o_S_WDATA(s_wdata),
        .i_S_GNT(s_gnt), .i_S_RDATA(s_rdata)
    );

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        we, re;
        logic [1:0]  hb;
        logic [31:0] wdata;
        int          slave;
        int          gnt_after;  // WAIT cycle (1-based) in which slave grants; 0 = never
        logic [31:0] srdata;
        logic        noise;      // other slaves grant throughout WAIT
        logic        drop_req;   // master drops request in first WAIT cycle
        logic [7:0]  exp_ce;
        logic [31:0] exp_saddr;
        logic        exp_we, exp_re;
        int          exp_waits;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [31:0] addr, input logic we,
            input logic re, input logic [1:0] hb, input logic [31:0] wdata, input int slave,
            input int gnt_after, input logic [31:0] srdata, input logic noise,
            input logic drop_req, input logic [7:0] exp_ce, input logic [31:0] exp_saddr,
            input logic exp_we, input logic exp_re, input int exp_waits, input int exp_lat,
            input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.name = name; v.addr = addr; v.we = we; v.re = re; v.hb = hb; v.wdata = wdata;
        v.slave = slave; v.gnt_after = gnt_after; v.srdata = srdata; v.noise = noise;
        v.drop_req = drop_req; v.exp_ce = exp_ce; v.exp_saddr = exp_saddr;
        v.exp_we = exp_we; v.exp_re = exp_re; v.exp_waits = exp_waits;
        v.exp_lat = exp_lat; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic fill_junk();
        for (int k = 0; k < N; k++) s_rdata[k*DW +: DW] = 32'hA5A5_0000 | 32'(k);
    endtask

    // Called at a negedge; drives one transaction and acts as the slave.
    task automatic run_vec(input vec_t v);
        int         c, w, bad_hold, lat;
        logic [7:0] ce_or;
        logic       seen, er;
        logic [31:0] rd;
        m_req = 1'b1; m_we = v.we; m_re = v.re; m_hb = v.hb;
        m_addr = v.addr; m_wdata = v.wdata;
        c = 1; w = 0; bad_hold = 0; lat = 0; ce_or = '0; seen = 1'b0; er = 1'b0; rd = '0;
        fill_junk();
        while (!seen && c < 40) begin
            @(negedge clk);
            c++;
            ce_or |= s_ce;
            if (m_gnt) begin
                seen = 1'b1; lat = c; rd = m_rdata; er = m_err;
                m_req = 1'b0; s_gnt = '0;
            end else if (s_req) begin
                w++;
                if (s_ce !== v.exp_ce || s_we !== v.exp_we || s_re !== v.exp_re ||
                    s_addr !== v.exp_saddr || s_wdata !== v.wdata || s_hb !== v.hb)
                    bad_hold++;
                if (v.drop_req) m_req = 1'b0;
                s_gnt = v.noise ? ~(8'b1 << v.slave) : 8'b0;
                fill_junk();
                if (w == v.gnt_after) begin
                    s_gnt[v.slave] = 1'b1;
                    s_rdata[v.slave*DW +: DW] = v.srdata;
                end
            end else begin
                s_gnt = '0;
            end
        end
        s_gnt = '0;
        m_req = 1'b0; m_we = 1'b0; m_re = 1'b0;
        chk({v.name, "_gnt_seen"}, 64'(seen), 64'd1);
        chk({v.name, "_latency"}, 64'(lat), 64'(v.exp_lat));
        chk({v.name, "_waits"}, 64'(w), 64'(v.exp_waits));
        chk({v.name, "_ce"}, 64'(ce_or), 64'(v.exp_ce));
        chk({v.name, "_slave_hold"}, 64'(bad_hold), 64'd0);
        chk({v.name, "_rdata"}, 64'(rd), 64'(v.exp_rdata));
        chk({v.name, "_err"}, 64'(er), 64'(v.exp_err));
        @(negedge clk);
        chk({v.name, "_single_pulse"}, 64'(m_gnt), 64'd0);
        chk({v.name, "_rdata_hold"}, 64'(m_rdata), 64'(v.exp_rdata));
    endtask

    initial begin
        int gcount;
        rst = 1'b1; m_req = 0; m_we = 0; m_re = 0; m_hb = 0; m_addr = 0; m_wdata = 0;
        s_gnt = '0; s_rdata = '0;

        //        name       addr          we re hb     wdata        sl ga srdata       nz dr ce     saddr         swe sre w  lat rdata        err
        vecs.push_back(mk("rd_s1",   32'h9000_0010, 0, 1, 2'b10, 32'h0,       1, 1, 32'hCAFEF00D, 0, 0, 8'h02, 32'h0000_0010, 0, 1, 1, 3, 32'hCAFEF00D, 0));
        vecs.push_back(mk("miss_lo", 32'h1000_0000, 0, 1, 2'b10, 32'h0,       0, 0, 32'h0,        0, 0, 8'h00, 32'h0,         0, 0, 0, 2, 32'h0,        ERR_ON));
        vecs.push_back(mk("wr_s2",   32'hA000_0000, 1, 0, 2'b00, 32'h41,      2, 4, 32'h7777_7777, 0, 0, 8'h04, 32'h0,        1, 0, 4, 6, 32'h0,        0));
        vecs.push_back(mk("rd_s1b",  32'h9000_0020, 0, 1, 2'b01, 32'h0,       1, 2, 32'h0BADCAFE, 0, 1, 8'h02, 32'h0000_0020, 0, 1, 2, 4, 32'h0BADCAFE, 0));
        vecs.push_back(mk("miss_7",  32'h7000_0004, 1, 0, 2'b00, 32'h1,       0, 0, 32'h0,        0, 0, 8'h00, 32'h0,         0, 0, 0, 2, 32'h0,        ERR_ON));
        vecs.push_back(mk("weré_s7", 32'hF000_1234, 1, 1, 2'b10, 32'h55,      7, 2, 32'h9999_9999, 0, 0, 8'h80, 32'h0000_1234, 1, 0, 2, 4, 32'h0,       0));
        vecs.push_back(mk("noise_s0",32'h8FFF_FFFC, 0, 1, 2'b10, 32'h0,       0, 3, 32'h1234_5678, 1, 0, 8'h01, 32'h0FFF_FFFC, 0, 1, 3, 5, 32'h1234_5678, 0));
        vecs.push_back(mk("gnt_at_to",32'hB000_0008,0, 1, 2'b10, 32'h0,       3, 15, 32'hDEADBEEF, 0, 0, 8'h08, 32'h0000_0008, 0, 1, 15, 17, 32'hDEADBEEF, 0));
`ifdef BUS_FABRIC_TIMEOUT_ERR_EN
        vecs.push_back(mk("timeout", 32'hB000_0000, 0, 1, 2'b10, 32'h0,       3, 0, 32'h0,        0, 0, 8'h08, 32'h0,         0, 1, 15, 17, 32'h0,      1));
`endif

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("reset_ce", 64'(s_ce), 64'd0);
        chk("reset_ctl", 64'({m_gnt, m_err, s_req, s_we, s_re, s_hb}), 64'd0);
        chk("reset_addr_data", {s_addr, s_wdata}, 64'd0);
        chk("reset_rdata", 64'(m_rdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset asserted two cycles into WAIT: drop the access, no grant.
        m_req = 1'b1; m_we = 1'b0; m_re = 1'b1; m_hb = 2'b10;
        m_addr = 32'h9000_0040; m_wdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_in_wait", 64'({s_ce, s_req}), 64'({8'h02, 1'b1}));
        #2 rst = 1'b1;
        #1;
        chk("rst_async_ce", 64'(s_ce), 64'd0);
        chk("rst_async_ctl", 64'({m_gnt, m_err, s_req, s_we, s_re, s_hb}), 64'd0);
        chk("rst_async_addr", 64'(s_addr), 64'd0);
        chk("rst_async_rdata", 64'(m_rdata), 64'd0);
        m_req = 1'b0; m_re = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        gcount = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (m_gnt || s_req) gcount++;
        end
        chk("no_gnt_after_rst", 64'(gcount), 64'd0);
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
